// File: rtl/spi_master_if.sv
// Host handshake and SPI pin bundle for spi_master.
// The master modport is the DUT's view; the slave modport is the host/pin side.
interface spi_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       SCK;
    logic       SS;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, tx_data, mode, MISO,
        output busy, done, rx_data, SCK, SS, MOSI
    );

    modport slave (
        output start, tx_data, mode, MISO,
        input  busy, done, rx_data, SCK, SS, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI master: start/busy/done host handshake, all four SPI modes, MSB first.
// SCK half-period is CLK_DIV system clocks; every output comes straight from a flop.
module spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input logic          clk,
    input logic          rst_n,
    spi_master_if.master bus
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [3:0] edge_cnt_q, edge_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [1:0] mode_q, mode_d;
    logic       sck_q, sck_d;
    logic       ss_q, ss_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       div_end, leading, capture, advance;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        mode_d     = mode_q;
        sck_d      = sck_q;
        ss_d       = ss_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_end    = (div_cnt_q == DIV_LAST);
        // edge_cnt holds the index of the upcoming toggle, so even indices are leading edges
        leading    = ~edge_cnt_q[0];
        capture    = 1'b0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = LEAD;
                    tx_shift_d = bus.tx_data;
                    rx_shift_d = 8'h00;
                    mode_d     = bus.mode;
                    mosi_d     = bus.tx_data[7];
                    sck_d      = bus.mode[1];
                    ss_d       = 1'b0;
                    busy_d     = 1'b1;
                    div_cnt_d  = 8'd0;
                    edge_cnt_d = 4'd0;
                end
            end
            LEAD, SHIFT: begin
                if (div_end) begin
                    div_cnt_d  = 8'd0;
                    sck_d      = ~sck_q;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (mode_q[0]) begin
                        capture = ~leading;
                        advance = leading && (edge_cnt_q != 4'd0);
                    end else begin
                        capture = leading;
                        advance = ~leading && (edge_cnt_q != 4'd15);
                    end
                    state_d = (edge_cnt_q == 4'd15) ? TRAIL : SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            TRAIL: begin
                if (div_end) begin
                    div_cnt_d = 8'd0;
                    state_d   = GAP;
                    ss_d      = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (div_end) begin
                    div_cnt_d = 8'd0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            rx_shift_d = {rx_shift_q[6:0], bus.MISO};
        end
        if (advance) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            mosi_d     = tx_shift_q[6];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= 8'd0;
            edge_cnt_q <= 4'd0;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            mode_q     <= 2'b00;
            sck_q      <= 1'b0;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            mode_q     <= mode_d;
            sck_q      <= sck_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.SCK     = sck_q;
    assign bus.SS      = ss_q;
    assign bus.MOSI    = mosi_q;
endmodule
